// File: rtl/audio_pkg.sv
// Shared audio types: default sample width, stereo pair, LRCLK polarity and
// the serializer state encoding.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam logic        LR_LEFT  = 1'b0;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT
    } tx_state_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Stereo sample handshake between the APU (master) and the I2S serializer (slave).
interface i2s_tx_if #(
    parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input  s_ready);
    modport slave  (input  s_valid, input  s_left, input  s_right, output s_ready);
endinterface

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo pairs with occupancy output; push and pop may
// coincide. Pointers wrap naturally at the power-of-two depth.
module i2s_sample_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter type         T          = audio_pkg::pair_t
) (
    input  logic                        clk_in,
    input  logic                        reset_n,
    input  logic                        push,
    input  T                            wr_data,
    input  logic                        pop,
    output T                            rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    T              mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers stereo pairs and serializes them MSB-first on SDATA,
// driven by synchronized, edge-detected BCLK/LRCLK inside the clk_in domain.
module i2s_tx #(
    parameter int unsigned SAMPLE_W    = audio_pkg::SAMPLE_W,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk_in,
    input  logic                        reset_n,
    input  logic                        bclk_in,
    input  logic                        lrclk_in,
    input  logic                        pll_locked,
    input  logic                        enable,
    i2s_tx_if.slave                     s,
    output logic                        i2s_sdata,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    import audio_pkg::*;

    localparam int unsigned CW = $clog2(SAMPLE_W);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } word_pair_t;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic                   bclk_hist;
    logic                   lr_prev;
    logic                   bclk_s;
    logic                   lr_s;
    logic                   bfall;
    logic                   left_bound;
    logic                   right_bound;
    logic                   run_ok;
    logic                   enable_d;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   load;
    word_pair_t             wr_pair;
    word_pair_t             rd_data;
    word_pair_t             popped;
    logic [SAMPLE_W-1:0]    shreg;
    logic [SAMPLE_W-1:0]    right_hold;
    logic [SAMPLE_W-1:0]    load_word;
    logic [CW-1:0]          bit_cnt;
    tx_state_t              state;

    assign bclk_s      = bclk_sync[SYNC_STAGES-1];
    assign lr_s        = lr_sync[SYNC_STAGES-1];
    assign bfall       = bclk_hist && !bclk_s;
    assign left_bound  = bfall && (lr_s != lr_prev) && (lr_s == LR_LEFT);
    assign right_bound = bfall && (lr_s != lr_prev) && (lr_s != LR_LEFT);
    assign run_ok      = enable && pll_locked;

    assign s.s_ready = !fifo_full;
    assign push      = s.s_valid && !fifo_full;
    assign wr_pair   = {s.s_left, s.s_right};
    assign pop       = run_ok && left_bound && (state != IDLE) && !fifo_empty;
    assign load      = run_ok && (((state != IDLE) && left_bound) || ((state == SHIFT) && right_bound));

    always_comb begin
        popped    = fifo_empty ? '0 : rd_data;
        load_word = left_bound ? popped.left : right_hold;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            bclk_hist <= 1'b0;
            lr_prev   <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_in};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk_in};
            bclk_hist <= bclk_s;
            if (bfall) lr_prev <= lr_s;
        end
    end

    i2s_sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .T          (word_pair_t)
    ) u_fifo (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (wr_pair),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Right word is captured at the left pop so the right slot never touches the FIFO.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            i2s_sdata  <= 1'b0;
            shreg      <= '0;
            right_hold <= '0;
            bit_cnt    <= '0;
            underrun   <= 1'b0;
            enable_d   <= 1'b0;
        end else begin
            enable_d <= enable;
            if (enable && !enable_d) underrun <= 1'b0;

            if (!run_ok) begin
                state     <= IDLE;
                i2s_sdata <= 1'b0;
                bit_cnt   <= '0;
            end else if (state == IDLE) begin
                i2s_sdata <= 1'b0;
                state     <= ARMED;
            end else if (load) begin
                state     <= SHIFT;
                i2s_sdata <= load_word[SAMPLE_W-1];
                shreg     <= {load_word[SAMPLE_W-2:0], 1'b0};
                bit_cnt   <= CW'(SAMPLE_W - 1);
                if (left_bound) begin
                    right_hold <= popped.right;
                    if (fifo_empty) underrun <= 1'b1;
                end
            end else if ((state == SHIFT) && bfall) begin
                if (bit_cnt != '0) begin
                    i2s_sdata <= shreg[SAMPLE_W-1];
                    shreg     <= {shreg[SAMPLE_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - 1'b1;
                end else begin
                    i2s_sdata <= 1'b0;
                end
            end
        end
    end
endmodule
